// File: rtl/histogram_readout.sv
`default_nettype none
// ============================================================================
// Module   : histogram_readout
// Purpose  : Read-side controller for a multi-lane histogram. On a start
//            pulse it freezes the lanes and sweeps the bin address. For each
//            bin it sums that bin's count across all lanes and streams
//            {bin, total} over a valid/ready interface. It can optionally
//            pulse a lane clear once the sweep is complete.
// Ports    : clock, reset      - rising-edge clock, synchronous active-high reset
//            start             - request one sweep (ignored while busy)
//            busy, freeze      - sweep in progress / lanes must hold their counts
//            hist_addr         - bin address broadcast to all lanes
//            lane_data         - lane n count at [n*COUNT_W +: COUNT_W]
//            clear_lanes       - one-cycle clear pulse to the lanes
//            out_valid/ready   - result beat handshake
//            out_bin/count/last- beat payload (bin, lane total, final-bin flag)
//            done              - one-cycle pulse at sweep completion
// Revision : 1.0 - initial release
// ============================================================================
module histogram_readout #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_BINS    = 8,
  parameter int COUNT_W     = 14,
  parameter int SUM_W       = 16,
  parameter int RD_LAT      = 1,
  parameter int CLEAR_AFTER = 1,
  localparam int BIN_W      = $clog2(NUM_BINS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         freeze,
  output logic [BIN_W-1:0]             hist_addr,
  input  logic [NUM_LANES*COUNT_W-1:0] lane_data,
  output logic                         clear_lanes,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BIN_W-1:0]             out_bin,
  output logic [SUM_W-1:0]             out_count,
  output logic                         out_last,
  output logic                         done
);

  localparam int LAT_W = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [BIN_W-1:0] c_LAST_BIN = BIN_W'(NUM_BINS - 1);
  localparam logic [LAT_W-1:0] c_RD_LAT   = LAT_W'(RD_LAT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_ISSUE  = 3'd2,
    S_WAIT   = 3'd3,
    S_SUM    = 3'd4,
    S_OUT    = 3'd5,
    S_CLEAR  = 3'd6,
    S_FIN    = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_busy;
  logic               w_clear;
  logic               w_done;
  logic [BIN_W-1:0]   r_bin;
  logic [LAT_W-1:0]   r_wait_cnt;
  logic [BIN_W-1:0]   r_hist_addr;
  logic               r_out_valid;
  logic [BIN_W-1:0]   r_out_bin;
  logic [SUM_W-1:0]   r_out_count;
  logic               r_out_last;
  logic [SUM_W-1:0]   w_sum;
  logic               w_handshake;
  logic               w_at_last;

  assign w_handshake = (r_state == S_OUT) && out_ready;
  assign w_at_last   = (r_bin == c_LAST_BIN);

  // Lane totals are accumulated at full output width so the sum never wraps.
  always_comb begin
    w_sum = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      w_sum = w_sum + SUM_W'(lane_data[n*COUNT_W +: COUNT_W]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b1;
    w_clear     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) begin
          w_state_nxt = S_SETTLE;
        end
      end
      // One frozen cycle lets any in-flight lane increment land before reads.
      S_SETTLE: w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt <= LAT_W'(1)) begin
          w_state_nxt = S_SUM;
        end
      end
      S_SUM: w_state_nxt = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (w_at_last) begin
            w_state_nxt = (CLEAR_AFTER != 0) ? S_CLEAR : S_FIN;
          end else begin
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_CLEAR: begin
        w_clear     = 1'b1;
        w_state_nxt = S_FIN;
      end
      S_FIN: begin
        // start seen here is deliberately dropped: FIN always returns to IDLE.
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_bin       <= '0;
      r_wait_cnt  <= '0;
      r_hist_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_bin   <= '0;
      r_out_count <= '0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bin <= '0;
          end
        end
        S_ISSUE: begin
          r_hist_addr <= r_bin;
          r_wait_cnt  <= c_RD_LAT;
        end
        S_WAIT: begin
          r_wait_cnt <= r_wait_cnt - LAT_W'(1);
        end
        S_SUM: begin
          r_out_count <= w_sum;
          r_out_bin   <= r_bin;
          r_out_last  <= w_at_last;
          r_out_valid <= 1'b1;
        end
        S_OUT: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            if (!w_at_last) begin
              r_bin <= r_bin + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = w_busy;
  assign freeze      = w_busy;
  assign clear_lanes = w_clear;
  assign done        = w_done;
  assign hist_addr   = r_hist_addr;
  assign out_valid   = r_out_valid;
  assign out_bin     = r_out_bin;
  assign out_count   = r_out_count;
  assign out_last    = r_out_last;

endmodule
`default_nettype wire
